// File: rtl/lab2_add_sequencer_pkg.sv
// Shared definitions for the two-requester multi-cycle adder:
// controller state encoding and the width of the shared adder slice.
package lab2_add_sequencer_pkg;

  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lab2_add_sequencer_ripple4.sv
// Four chained full adders. Besides the 4-bit sum it exposes the carry
// into bit 3 (c3) and the carry out of bit 3 (c4). Signed overflow of the
// top slice is c3 ^ c4.
module lab2_add_sequencer_ripple4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);

  logic [4:0] c;

  // Ripple chain: the carry is propagated when a^b, otherwise generated from b.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = c[i] ^ a[i] ^ b[i];
      c[i+1] = (a[i] ^ b[i]) ? c[i] : b[i];
    end
  end

  assign c3 = c[3];
  assign c4 = c[4];

endmodule

// File: rtl/lab2_add_sequencer.sv
// Multi-cycle adder controller. Two requesters share one 4-bit ripple
// slice through a round-robin arbiter. Each operation adds one slice per
// cycle, with the carry held in a register between slices. A one-cycle
// done pulse then presents the result, which holds until the next done.
module lab2_add_sequencer
  import lab2_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_id_q, done_id_d;
  // Operand capture and the partial-sum accumulator carry no reset: they
  // are always rewritten at grant before being used.
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             id_q, id_d;
  logic             pick0;

  logic [3:0] sl_a, sl_b, sl_s;
  logic       sl_c3, sl_c4;

  assign sl_a = a_q[k_q*SLICE +: SLICE];
  assign sl_b = b_q[k_q*SLICE +: SLICE];

  lab2_add_sequencer_ripple4 u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .s   (sl_s),
    .c3  (sl_c3),
    .c4  (sl_c4)
  );

  // Next-state logic: arbitrate and latch in IDLE, add one slice per RUN cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    k_d       = k_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    id_d      = id_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    // On a tie, requester 0 wins only when requester 1 was served last.
    pick0     = req0 && (!req1 || last_q);
    unique case (state_q)
      ST_IDLE: begin
        if (!rst && (req0 || req1)) begin
          gnt0    = pick0;
          gnt1    = !pick0;
          id_d    = !pick0;
          last_d  = !pick0;
          a_d     = pick0 ? a0 : a1;
          b_d     = pick0 ? b0 : b1;
          carry_d = pick0 ? cin0 : cin1;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d[k_q*SLICE +: SLICE] = sl_s;
        carry_d = sl_c4;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          sum_d     = acc_d;
          cout_d    = sl_c4;
          ovf_d     = sl_c3 ^ sl_c4;
          done_id_d = id_q;
          k_d       = '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      k_q       <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      k_q       <= k_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
    end
  end

  // Operand and accumulator registers; no reset needed.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
    id_q  <= id_d;
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign done_id  = done_id_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
